// File: rtl/nibble_serial_addsub_if.sv
// Operand and result valid/ready bundle for the nibble-serial adder/subtractor.
// The producer/consumer side is the master; the arithmetic block is the slave.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/sub computed one nibble per cycle, LSB first,
// on a single reused 4-bit carry-skip slice.
module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    nibble_serial_addsub_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             in_ready;
    logic             out_valid;
    logic             last;

    logic [3:0]       a_n, b_n, g, p, s_n;
    logic [4:0]       rc;
    logic             skip;
    logic             c_nib;

    assign last = (idx_q == IW'(NIB - 1));

    // Operands shift right each RUN cycle, so the slice always sees bits [3:0].
    always_comb begin
        a_n   = a_q[3:0];
        b_n   = b_q[3:0];
        g     = a_n & b_n;
        p     = a_n ^ b_n;
        rc[0] = c_q;
        for (int i = 0; i < 4; i++) begin
            rc[i+1] = g[i] | (p[i] & rc[i]);
        end
        s_n   = p ^ rc[3:0];
        skip  = &p;
        c_nib = skip ? c_q : rc[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid && in_ready) state_d = RUN;
            RUN:  if (last) state_d = DONE;
            DONE: if (out_valid && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready stays low while rst is held, even once the state is IDLE.
    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = (state_q == DONE);
    end

    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        c_d    = c_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (state_q == IDLE && bus.in_valid && in_ready) begin
            a_d   = bus.A;
            b_d   = bus.sub ? ~bus.B : bus.B;
            c_d   = bus.sub ? 1'b1 : bus.cin;
            idx_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_q >> 4;
            b_d   = b_q >> 4;
            acc_d = {s_n, acc_q[WIDTH-1:4]};
            c_d   = c_nib;
            idx_d = idx_q + IW'(1);
            // Result ports change only when the whole word is complete.
            if (last) begin
                sum_d  = {s_n, acc_q[WIDTH-1:4]};
                cout_d = c_nib;
                ovf_d  = rc[3] ^ c_nib;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub (WIDTH=16): literal checks per
// vector plus a per-cycle comparison against an arithmetic reference model.
module tb_nibble_serial_addsub;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           e;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    nibble_serial_addsub_if #(.WIDTH(W)) bus ();

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Result from plain integer arithmetic on the operands.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        res_t r;
        int   sa, sb, sr, ur;
        sa = $signed(a);
        sb = $signed(b);
        sr = s ? sa - sb : sa + sb + int'(c);
        ur = s ? int'(a) - int'(b) : int'(a) + int'(b) + int'(c);
        r.s = W'(ur);
        r.c = s ? (a >= b) : (ur > 65535);
        r.o = (sr > 32767) || (sr < -32768);
        r.e = 0;
        return r;
    endfunction

    res_t q[$];
    res_t last = '{16'h0, 1'b0, 1'b0, 0};
    bit   en = 1'b0;

    always @(negedge clk) begin
        logic exp_ov, exp_ir;
        res_t r;
        exp_ov = (q.size() != 0) && (cyc >= q[0].e + NIB);
        exp_ir = !rst && (q.size() == 0);
        if (exp_ov) last = q[0];
        if (en) begin
            chk("m_out_valid", bus.out_valid, exp_ov);
            chk("m_in_ready", bus.in_ready, exp_ir);
            chk("m_sum", bus.sum, last.s);
            chk("m_cout", bus.cout, last.c);
            chk("m_ovf", bus.ovf, last.o);
        end
        if (rst) begin
            en = 1'b1;
            q.delete();
            last = '{16'h0, 1'b0, 1'b0, 0};
        end else begin
            if (exp_ov && bus.out_ready) void'(q.pop_front());
            if (exp_ir && bus.in_valid) begin
                r = model(bus.A, bus.B, bus.cin, bus.sub);
                r.e = cyc + 1;
                q.push_back(r);
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s);
        bit ok;
        @(posedge clk);
        #1;
        bus.A = a;
        bus.B = b;
        bus.cin = c;
        bus.sub = s;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        chk("accepted", ok, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A = ~a;
        bus.B = a ^ b;
        bus.cin = ~c;
        bus.sub = ~s;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s,
                          input logic [W-1:0] es, input logic ec,
                          input logic eo, input int hold);
        bit ok;
        int lat;
        start_op(a, b, c, s);
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            lat++;
            ok = bus.out_valid;
        end
        chk("latency", lat, NIB + 1);
        chk("sum", bus.sum, es);
        chk("cout", bus.cout, ec);
        chk("ovf", bus.ovf, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = i[0];
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            bus.sub = i[1];
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_sum", bus.sum, es);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", bus.out_valid, 1'b0);
        chk("release_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_valid", bus.out_valid, 1'b0);
        chk("post_rst_sum", bus.sum, 16'h0000);

        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h0002, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        run_op(16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        run_op(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 6);

        start_op(16'h00FF, 16'h0F0F, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_rst_valid", bus.out_valid, 1'b0);
        chk("midrun_rst_sum", bus.sum, 16'h0000);
        chk("midrun_rst_in_ready", bus.in_ready, 1'b1);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
